// File: rtl/pass_done_reporter.sv
// rtl/pass_done_reporter.sv - pass_done event capture, timestamp, FIFO and run sequencer
// Queues every non-NOOP MTC0 report with a cycle stamp and drains it to the host stream.
module pass_done_reporter #(
   parameter int FIFO_DEPTH = 8,
   parameter int CYCLE_W    = 32,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [15:0]          pd_value,
   input  logic [7:0]           pd_code,
   output logic                 host_valid,
   input  logic                 host_ready,
   output logic [CYCLE_W+23:0]  host_data,
   output logic [CNT_W-1:0]     pass_count,
   output logic [CNT_W-1:0]     fail_count,
   output logic                 any_fail,
   output logic                 overflow,
   output logic                 running,
   output logic                 done
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = CYCLE_W + 24;

   localparam logic [7:0] MTC0_NOOP = 8'h00;
   localparam logic [7:0] MTC0_PASS = 8'h01;
   localparam logic [7:0] MTC0_FAIL = 8'h02;
   localparam logic [7:0] MTC0_DONE = 8'h03;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   logic [1:0]         state;
   logic [CYCLE_W-1:0] cycle;
   logic [AW:0]        wptr, rptr, occ;
   logic [DW-1:0]      mem [FIFO_DEPTH];
   logic               empty, full, accept, pop, push, drop, last_pop;

   assign empty    = (wptr == rptr);
   assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign occ      = wptr - rptr;
   assign accept   = ((state == S_IDLE) || (state == S_RUN)) && (pd_code != MTC0_NOOP);
   assign host_valid = !empty && (state != S_HALT);
   assign pop      = host_valid && host_ready;
   assign push     = accept && (!full || pop);
   assign drop     = accept && full && !pop;
   // Halt is entered the cycle after the final record leaves, not one cycle later.
   assign last_pop = pop && (occ == {{AW{1'b0}}, 1'b1});
   assign host_data = host_valid ? mem[rptr[AW-1:0]] : '0;
   assign running  = (state == S_RUN);
   assign done     = (state == S_HALT);

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr[AW-1:0]] <= {pd_code, pd_value, cycle};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_count <= '0;
         fail_count <= '0;
         any_fail   <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (accept && (pd_code == MTC0_PASS) && (pass_count != '1))
            pass_count <= pass_count + 1'b1;
         if (accept && (pd_code == MTC0_FAIL)) begin
            any_fail <= 1'b1;
            if (fail_count != '1)
               fail_count <= fail_count + 1'b1;
         end
         if (drop)
            overflow <= 1'b1;
      end
   end

   // The start event itself occupies stamp 0, so RUN begins counting from 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cycle <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (pd_code == MTC0_DONE) begin
                     state <= S_DRAIN;
                  end else begin
                     state <= S_RUN;
                     cycle <= {{(CYCLE_W-1){1'b0}}, 1'b1};
                  end
               end
            end
            S_RUN: begin
               if (cycle != '1)
                  cycle <= cycle + 1'b1;
               if (accept && (pd_code == MTC0_DONE))
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (empty || last_pop)
                  state <= S_HALT;
            end
            default: state <= S_HALT;
         endcase
      end
   end
endmodule

// File: tb/tb_pass_done_reporter.sv
// tb/tb_pass_done_reporter.sv - scoreboard bench for pass_done_reporter
module tb_pass_done_reporter;
   localparam int DEPTH = 8;
   localparam logic [7:0] NOOP = 8'h00, PASS = 8'h01, FAIL = 8'h02, DONE = 8'h03;
   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] pd_value = '0;
   logic [7:0]  pd_code = '0;
   logic        host_ready = 1'b0;
   logic        host_valid;
   logic [55:0] host_data;
   logic [15:0] pass_count, fail_count;
   logic        any_fail, overflow, running, done;

   int total = 0;
   int bad = 0;
   int npops = 0;

   logic [55:0] mq[$];
   int          mst = M_IDLE;
   logic [31:0] mcnt = '0;
   int          mpass = 0, mfail = 0;
   logic        many = 1'b0, mov = 1'b0;

   always #5 clk = ~clk;

   pass_done_reporter dut (
      .clk(clk), .rst(rst), .pd_value(pd_value), .pd_code(pd_code),
      .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
      .pass_count(pass_count), .fail_count(fail_count), .any_fail(any_fail),
      .overflow(overflow), .running(running), .done(done)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_flags();
      chk("pass_count", pass_count, mpass);
      chk("fail_count", fail_count, mfail);
      chk("any_fail", any_fail, many);
      chk("overflow", overflow, mov);
      chk("running", running, mst == M_RUN);
      chk("done", done, mst == M_HALT);
   endtask

   task automatic model_clear();
      mq.delete();
      mst = M_IDLE; mcnt = '0; mpass = 0; mfail = 0; many = 1'b0; mov = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; pd_code = NOOP; pd_value = '0; host_ready = 1'b0;
      model_clear();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // One clock: drive inputs, settle pops/pushes in the model, then check flags.
   task automatic cyc(input logic [7:0] c, input logic [15:0] v, input logic r);
      int st0;
      logic [55:0] e;
      pd_code = c; pd_value = v; host_ready = r;
      st0 = mst;
      chk("host_valid", host_valid, (mq.size() > 0) && (mst != M_HALT));
      if ((mq.size() > 0) && r && (mst != M_HALT)) begin
         e = mq.pop_front();
         chk("host_data", host_data, e);
         npops++;
      end
      if (((st0 == M_IDLE) || (st0 == M_RUN)) && (c != NOOP)) begin
         if (c == PASS && mpass != 16'hffff) mpass++;
         if (c == FAIL) begin
            many = 1'b1;
            if (mfail != 16'hffff) mfail++;
         end
         if (mq.size() < DEPTH) mq.push_back({c, v, (st0 == M_IDLE) ? 32'd0 : mcnt});
         else mov = 1'b1;
         if (c == DONE) mst = M_DRAIN;
         else if (st0 == M_IDLE) begin
            mst = M_RUN;
            mcnt = 32'd1;
         end
      end
      if (st0 == M_RUN && mcnt != 32'hffffffff) mcnt = mcnt + 1;
      if (st0 == M_DRAIN && mq.size() == 0) mst = M_HALT;
      @(posedge clk); #1;
      chk_flags();
   endtask

   initial begin
      #2;
      chk("rst_valid", host_valid, 1'b0);
      chk("rst_data", host_data, 56'd0);
      chk_flags();
      @(posedge clk); #1;
      rst = 1'b0;

      // 1) first event at cycle 0
      cyc(PASS, 16'h0011, 1'b1);
      chk("t1_valid", host_valid, 1'b1);
      chk("t1_data", host_data, {8'h01, 16'h0011, 32'd0});
      chk("t1_pass", pass_count, 16'd1);
      chk("t1_running", running, 1'b1);
      cyc(NOOP, 16'h0, 1'b1);

      // 2) FAIL after 3 idle cycles carries stamp 4
      do_reset();
      cyc(PASS, 16'h0001, 1'b1);
      for (int i = 0; i < 3; i++) cyc(NOOP, 16'h0, 1'b1);
      cyc(FAIL, 16'hBEEF, 1'b1);
      chk("t2_data", host_data, {8'h02, 16'hBEEF, 32'd4});
      chk("t2_fail", fail_count, 16'd1);
      chk("t2_any", any_fail, 1'b1);
      cyc(NOOP, 16'h0, 1'b1);

      // 3) overflow with host stalled, then drain in order
      do_reset();
      for (int i = 0; i < 9; i++) cyc(PASS, 16'(i), 1'b0);
      chk("t3_ovf", overflow, 1'b1);
      chk("t3_pass", pass_count, 16'd9);
      npops = 0;
      for (int i = 0; i < 10; i++) cyc(NOOP, 16'h0, 1'b1);
      chk("t3_npops", npops, 8);
      chk("t3_empty", host_valid, 1'b0);

      // 4) push and pop while full
      do_reset();
      for (int i = 0; i < 8; i++) cyc(PASS, 16'(16'h100 + i), 1'b0);
      cyc(FAIL, 16'h0055, 1'b1);
      chk("t4_ovf", overflow, 1'b0);
      for (int i = 0; i < 9; i++) cyc(NOOP, 16'h0, 1'b1);
      chk("t4_empty", host_valid, 1'b0);

      // 5) DONE then ignored PASS, halt after last pop
      do_reset();
      cyc(PASS, 16'h0001, 1'b1);
      cyc(DONE, 16'h0000, 1'b1);
      cyc(PASS, 16'h0002, 1'b1);
      chk("t5_pass", pass_count, 16'd1);
      chk("t5_done", done, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc(PASS, 16'h0003, 1'b1);
         chk("t5_hold_valid", host_valid, 1'b0);
      end

      // 6) reset mid-run with queued entries
      do_reset();
      for (int i = 0; i < 3; i++) cyc(PASS, 16'(16'h200 + i), 1'b0);
      rst = 1'b1;
      #1;
      chk("t6_valid", host_valid, 1'b0);
      chk("t6_data", host_data, 56'd0);
      model_clear();
      chk_flags();
      @(posedge clk); #1;
      rst = 1'b0;
      cyc(NOOP, 16'h0, 1'b1);
      chk("t6_after", host_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
